// File: rtl/instr_fetch_buffer_pkg.sv
// rtl/instr_fetch_buffer_pkg.sv - shared processor widths and fetch buffer defaults
package instr_fetch_buffer_pkg;

  localparam int PC_W      = 16;
  localparam int INSTR_W   = 16;
  localparam int IFB_AW    = PC_W;
  localparam int IFB_DW    = INSTR_W;
  localparam int IFB_DEPTH = 2;

endpackage

// File: rtl/instr_fetch_buffer_fifo.sv
// rtl/instr_fetch_buffer_fifo.sv - instruction word FIFO with synchronous flush
module ifb_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_ONE;
      if (pop_i)  rptr_d = rptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clr_i && push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - instruction prefetch: read issue, jump discard, decoder handshake
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int AW    = IFB_AW,
  parameter int DW    = IFB_DW,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic [AW-1:0] pc_addr,
  input  logic          jump,
  output logic          pc_incr,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ins_out,
  output logic          ins_valid,
  input  logic          ins_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic          inflight_q, inflight_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          issue, push, pop;

  // A pop frees a slot this cycle, so it counts toward room for a new read.
  always_comb begin
    pop        = ins_valid && ins_ready && !jump;
    push       = inflight_q && !discard_q;
    occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue      = rst_n && fetch_en && !jump && (occupancy < DEPTH_C);
    inflight_d = issue;
    discard_d  = jump && inflight_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  ifb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (jump),
    .push_i  (push),
    .data_i  (imem_rdata),
    .pop_i   (pop),
    .data_o  (ins_out),
    .count_o (count)
  );

  assign imem_addr = pc_addr;
  assign imem_rd   = issue;
  assign pc_incr   = issue;
  assign ins_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - self-checking bench for instr_fetch_buffer
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b1;
  logic        jump = 1'b0;
  logic        ins_ready = 1'b1;
  logic [15:0] jump_tgt = 16'h0;
  logic [15:0] pc_q;
  logic [15:0] imem_rdata_q;
  logic        pc_incr, imem_rd, ins_valid;
  logic [15:0] imem_addr, ins_out;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.AW(16), .DW(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .pc_addr    (pc_q),
    .jump       (jump),
    .pc_incr    (pc_incr),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata_q),
    .ins_out    (ins_out),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready)
  );

  // Program counter and instruction memory: word at addr is addr + 0x1000.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= 16'h0;
      imem_rdata_q <= 16'h0;
    end else begin
      if (jump)         pc_q <= jump_tgt;
      else if (pc_incr) pc_q <= pc_q + 16'd1;
      if (imem_rd) imem_rdata_q <= imem_addr + 16'h1000;
    end
  end

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        exp_rd;
    logic        exp_valid;
    logic [15:0] exp_addr;
    logic [15:0] exp_out;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        hold_pending = 1'b0;
  logic [15:0] prev_out = 16'h0;
  logic        forbid_en = 1'b0;
  logic [15:0] forbid_word = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic q, input logic rd,
                     input logic v, input logic [15:0] a, input logic [15:0] o);
    vec_t t;
    t.rst = r; t.fe = f; t.rdy = q; t.exp_rd = rd; t.exp_valid = v;
    t.exp_addr = a; t.exp_out = o;
    vq.push_back(t);
  endtask

  // Called at the falling edge: scoreboard pop on transfer, hold and stale checks.
  task automatic monitor();
    logic [15:0] exp_w;
    if (rst_n) begin
      if (hold_pending && ins_valid) chk("hold_stable", ins_out, prev_out);
      if (ins_valid && ins_ready && !jump) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra: got %h expected no transfer at %0t", ins_out, $time);
        end else begin
          exp_w = sb.pop_front();
          chk("stream_word", ins_out, exp_w);
        end
      end
      if (forbid_en && ins_valid) chk("no_stale_word", ins_out == forbid_word, 1'b0);
      hold_pending = ins_valid && !ins_ready && !jump;
      prev_out     = ins_out;
    end else begin
      hold_pending = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic q, input logic j,
                      input logic [15:0] t);
    @(posedge clk);
    #2;
    rst_n = r; fetch_en = f; ins_ready = q; jump = j; jump_tgt = t;
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    // rst fe rdy | rd valid addr out
    add(1, 1, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 1, 1, 0, 16'h0000, 16'h0000);
    add(0, 1, 1, 1, 0, 16'h0001, 16'h0000);
    add(0, 1, 1, 1, 1, 16'h0002, 16'h1000);
    add(0, 1, 1, 1, 1, 16'h0003, 16'h1001);
    add(0, 1, 1, 1, 1, 16'h0004, 16'h1002);
    add(0, 0, 1, 0, 1, 16'h0005, 16'h1003);
    add(0, 0, 1, 0, 1, 16'h0005, 16'h1004);
    add(0, 0, 1, 0, 0, 16'h0005, 16'h0000);
    add(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 1, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 1, 0, 16'h0001, 16'h0000);
    add(0, 1, 0, 0, 1, 16'h0002, 16'h1000);
    add(0, 1, 0, 0, 1, 16'h0002, 16'h1000);
    add(0, 1, 0, 0, 1, 16'h0002, 16'h1000);
    add(0, 1, 1, 1, 1, 16'h0002, 16'h1000);
    add(0, 1, 1, 1, 1, 16'h0003, 16'h1001);
    add(0, 1, 1, 1, 1, 16'h0004, 16'h1002);
    add(0, 1, 1, 1, 1, 16'h0005, 16'h1003);

    foreach (vq[i]) begin
      if (!vq[i].rst && vq[i].rdy && vq[i].exp_valid) sb.push_back(vq[i].exp_out);
      step(!vq[i].rst, vq[i].fe, vq[i].rdy, 1'b0, 16'h0);
      chk($sformatf("v%0d_imem_rd", i), imem_rd, vq[i].exp_rd);
      chk($sformatf("v%0d_pc_incr", i), pc_incr, vq[i].exp_rd);
      chk($sformatf("v%0d_ins_valid", i), ins_valid, vq[i].exp_valid);
      chk($sformatf("v%0d_imem_addr", i), imem_addr, vq[i].exp_addr);
      if (vq[i].exp_valid || vq[i].rst)
        chk($sformatf("v%0d_ins_out", i), ins_out, vq[i].exp_out);
    end
    chk("table_sb_empty", sb.size(), 0);

    // Jump while the read of 0x0003 is outstanding.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    sb.push_back(16'h1000); sb.push_back(16'h1001);
    sb.push_back(16'h1040); sb.push_back(16'h1041); sb.push_back(16'h1042);
    forbid_en = 1'b1; forbid_word = 16'h1003;
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040);
    chk("jump_no_issue", imem_rd, 1'b0);
    chk("jump_head_shown", ins_out, 16'h1002);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("jump_flush", ins_valid, 1'b0);
    chk("jump_target_rd", imem_rd, 1'b1);
    chk("jump_target_addr", imem_addr, 16'h0040);
    drain("jump_drain", 20);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    forbid_en = 1'b0;

    // Asynchronous reset with two words buffered from 0x0080.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("pre_reset_valid", ins_valid, 1'b1);
    chk("pre_reset_head", ins_out, 16'h1080);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", ins_valid, 1'b0);
    chk("areset_imem_rd", imem_rd, 1'b0);
    chk("areset_pc_incr", pc_incr, 1'b0);
    chk("areset_ins_out", ins_out, 16'h0000);
    hold_pending = 1'b0;
    sb.push_back(16'h1000); sb.push_back(16'h1001);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("release_rd", imem_rd, 1'b1);
    chk("release_addr", imem_addr, 16'h0000);
    drain("areset_drain", 20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
